decomb: RTL and testbench

//  Receive-side unpacker for the comb packing format. Input: 64-bit packed data word + 64-bit marker word S.

---
 rtl/decomb_pkg.sv | 39 +++
 rtl/decomb_if.sv | 38 +++
 rtl/decomb_field_extract.sv | 67 ++++++
 rtl/decomb.sv | 124 ++++++++++++
 tb/tb_decomb.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decomb_pkg.sv
// -----------------------------------------------------------------------------
// decomb_pkg
//   Shared sizes, FSM state encoding and a small bit-insert helper for the comb
//   unpacker.
//   W_PKT    : width of the packed data word and of the MSB marker word
//   W_FIELD  : width of each recovered value
//   N_FIELDS : number of values carried by one packet
// -----------------------------------------------------------------------------
package decomb_pkg;

  localparam int W_PKT    = 64;
  localparam int W_FIELD  = 16;
  localparam int N_FIELDS = 2;

  // len counts 0..W_FIELD, so it needs one extra bit beyond log2(W_FIELD).
  localparam int LEN_W  = $clog2(W_FIELD + 1);
  localparam int FIDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Returns v with bit 'pos' replaced by b. Positions at or beyond W_FIELD
  // leave v unchanged, so an over-long field never corrupts the value.
  function automatic logic [W_FIELD-1:0] set_bit(input logic [W_FIELD-1:0] v,
                                                 input logic [LEN_W-1:0]   pos,
                                                 input logic               b);
    logic [W_FIELD-1:0] r;
    r = v;
    for (int i = 0; i < W_FIELD; i++) begin
      if (pos == LEN_W'(i)) r[i] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/decomb_if.sv
// -----------------------------------------------------------------------------
// decomb_if
//   Packet-in / value-out bus of the comb unpacker.
//   start, in_data, in_S : packet request (in_data/in_S sampled only when start
//                          is accepted in IDLE)
//   out_b, out_valid     : recovered value, LSB-aligned
//   out_ready            : downstream accepts out_b
//   busy, done, err      : status (busy outside IDLE, one-cycle done, sticky err)
//
//   Handshake: out_b transfers on a rising clk edge where out_valid && out_ready.
//   Once out_valid is high it stays high, and out_b stays unchanged, until that
//   transfer happens; out_valid never depends combinationally on out_ready.
//   master = packet source / value sink, slave = the unpacker.
// -----------------------------------------------------------------------------
interface decomb_if;
  import decomb_pkg::*;

  logic               start;
  logic [W_PKT-1:0]   in_data;
  logic [W_PKT-1:0]   in_S;
  logic [W_FIELD-1:0] out_b;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, in_data, in_S, out_ready,
    input  out_b, out_valid, busy, done, err
  );

  modport slave (
    input  start, in_data, in_S, out_ready,
    output out_b, out_valid, busy, done, err
  );

endinterface

// File: rtl/decomb_field_extract.sv
// -----------------------------------------------------------------------------
// decomb_field_extract
//   Bit-serial datapath: data and marker shift registers, field accumulator and
//   field length counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture in_data/in_s, clear acc and len
//   step      : take data_sr[0] into acc[len], shift both regs right, len++
//   clr       : clear acc and len (between fields)
//   acc_next  : accumulator with the bit currently at the head inserted,
//               i.e. the completed field when s_bit is set
//   s_bit     : marker bit at the head (current bit is a field MSB)
//   s_empty   : no marker bits remain
//   len_zero  : no bits taken for the current field yet
//   len_max   : W_FIELD-1 bits already taken (this step is the last legal one)
// -----------------------------------------------------------------------------
module decomb_field_extract
  import decomb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               clr,
  input  logic [W_PKT-1:0]   in_data,
  input  logic [W_PKT-1:0]   in_s,
  output logic [W_FIELD-1:0] acc_next,
  output logic               s_bit,
  output logic               s_empty,
  output logic               len_zero,
  output logic               len_max
);

  logic [W_PKT-1:0]   data_sr;
  logic [W_PKT-1:0]   s_sr;
  logic [W_FIELD-1:0] acc;
  logic [LEN_W-1:0]   len;

  // Right shifts fill with zeros, so the registers drain instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr <= '0;
      s_sr    <= '0;
      acc     <= '0;
      len     <= '0;
    end else if (load) begin
      data_sr <= in_data;
      s_sr    <= in_s;
      acc     <= '0;
      len     <= '0;
    end else if (clr) begin
      acc     <= '0;
      len     <= '0;
    end else if (step) begin
      acc     <= acc_next;
      data_sr <= {1'b0, data_sr[W_PKT-1:1]};
      s_sr    <= {1'b0, s_sr[W_PKT-1:1]};
      len     <= len + LEN_W'(1);
    end
  end

  assign acc_next = set_bit(acc, len, data_sr[0]);
  assign s_bit    = s_sr[0];
  assign s_empty  = ~|s_sr;
  assign len_zero = (len == '0);
  assign len_max  = (len == LEN_W'(W_FIELD - 1));

endmodule

// File: rtl/decomb.sv
// -----------------------------------------------------------------------------
// decomb
//   Receive-side unpacker for the comb packing format. Field k occupies
//   data[e_k:p_k] with in_S[e_k]=1 marking its MSB; fields are recovered
//   bit-serially and handed out one per out_valid/out_ready transfer.
//   Missing fields (no markers left) decode as 0. A field with no marker within
//   W_FIELD bits sets the sticky err and ends the packet without output.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : decomb_if.slave (start/in_data/in_S, out_b/out_valid/out_ready,
//               busy/done/err)
//   dbg_state : current FSM state
// -----------------------------------------------------------------------------
module decomb
  import decomb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  decomb_if.slave bus,
  output state_t  dbg_state
);

  state_t             state;
  state_t             state_nx;
  logic [FIDX_W-1:0]  fidx;
  logic [W_FIELD-1:0] out_b_q;
  logic               err_q;

  logic               load;
  logic               step;
  logic               clr;
  logic               out_valid;
  logic               busy;
  logic               done;

  logic [W_FIELD-1:0] acc_next;
  logic               s_bit;
  logic               s_empty;
  logic               len_zero;
  logic               len_max;

  logic               zero_field;
  logic               fire;
  logic               last_field;

  decomb_field_extract u_fx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .clr      (clr),
    .in_data  (bus.in_data),
    .in_s     (bus.in_S),
    .acc_next (acc_next),
    .s_bit    (s_bit),
    .s_empty  (s_empty),
    .len_zero (len_zero),
    .len_max  (len_max)
  );

  // A field that has not started and has no marker left is an implicit zero.
  assign zero_field = len_zero && s_empty;
  assign fire       = out_valid && bus.out_ready;
  assign last_field = (fidx == FIDX_W'(N_FIELDS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (zero_field)   state_nx = ST_EMIT;
        else if (s_bit)   state_nx = ST_EMIT;
        else if (len_max) state_nx = ST_DONE;
      end
      ST_EMIT: if (fire) state_nx = last_field ? ST_DONE : ST_SCAN;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    out_valid = (state == ST_EMIT);
    load      = (state == ST_IDLE) && bus.start;
    step      = (state == ST_SCAN) && !zero_field;
    clr       = (state == ST_EMIT) && fire;
  end

  // Output value, error flag and field index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_b_q <= '0;
      err_q   <= 1'b0;
      fidx    <= '0;
    end else begin
      if (load) begin
        err_q <= 1'b0;
        fidx  <= '0;
      end
      if (state == ST_SCAN) begin
        if (zero_field)   out_b_q <= '0;
        else if (s_bit)   out_b_q <= acc_next;
        else if (len_max) err_q   <= 1'b1;
      end
      if (clr && !last_field) fidx <= fidx + FIDX_W'(1);
    end
  end

  assign bus.out_b     = out_b_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_decomb.sv
// -----------------------------------------------------------------------------
// tb_decomb
//   Directed bench for decomb. A comb-format decoder model (plain arithmetic on
//   the marker word) fills an expected queue of values and per-field scan
//   lengths; one negedge compare process checks every output transfer, hold
//   stability, latency and the done/err status against it.
// -----------------------------------------------------------------------------
module tb_decomb;
  import decomb_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  decomb_if bus ();

  decomb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int                 n_vec = 0;
  int                 n_err = 0;
  logic [W_FIELD-1:0] exp_q[$];
  int                 lat_q[$];
  logic               exp_err = 1'b0;
  int                 ncyc = 0;
  int                 ref_cyc = 0;
  int                 done_cnt = 0;
  logic               prev_valid = 1'b0;
  logic               prev_ready = 1'b0;
  logic [W_FIELD-1:0] held_b = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Walks the marker word: each field ends at the next set marker bit at or
  // above the current position; no marker left means a zero field.
  task automatic model_packet(input logic [63:0] d, input logic [63:0] s);
    int          p;
    int          e;
    int          l;
    logic [63:0] dv;
    p       = 0;
    exp_err = 1'b0;
    for (int k = 0; k < N_FIELDS; k++) begin
      if ((s >> p) == 64'd0) begin
        exp_q.push_back('0);
        lat_q.push_back(1);
      end else begin
        e = p;
        while (s[e] == 1'b0) e++;
        l = e - p + 1;
        if (l > W_FIELD) begin
          exp_err = 1'b1;
          break;
        end
        dv = (d >> p) & ((64'd1 << l) - 64'd1);
        exp_q.push_back(dv[W_FIELD-1:0]);
        lat_q.push_back(l);
        p = e + 1;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.start && !bus.busy) ref_cyc = ncyc;
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got out_b 0x%0h, expected no output", bus.out_b);
          end else begin
            check("out_b", 64'(bus.out_b), 64'(exp_q[0]));
            check("field_latency", 64'(ncyc - ref_cyc), 64'(1 + lat_q[0]));
          end
        end else begin
          check("out_b_hold", 64'(bus.out_b), 64'(held_b));
        end
        held_b = bus.out_b;
        if (bus.out_ready) begin
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
          ref_cyc = ncyc;
        end
      end else if (prev_valid && !prev_ready) begin
        check("valid_hold", 64'(bus.out_valid), 64'd1);
      end
      if (bus.done) begin
        done_cnt++;
        check("err_at_done", 64'(bus.err), 64'(exp_err));
        check("fields_left_at_done", 64'(exp_q.size()), 64'd0);
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
    end
  end

  // ---------------- driver ----------------
  // Issues one packet and runs it to done. stall=1 holds out_ready low for five
  // cycles on each output and pulses start while busy.
  task automatic run_packet(input logic [63:0] d, input logic [63:0] s, input bit stall,
                            output int lat1, output int cyc_done);
    int cyc;
    int hold;
    int done0;
    bit seen_done;
    done0         = done_cnt;
    lat1          = -1;
    cyc_done      = -1;
    hold          = 0;
    seen_done     = 1'b0;
    bus.out_ready = !stall;
    bus.in_data   = d;
    bus.in_S      = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.in_data = {$urandom, $urandom};
    bus.in_S    = {$urandom, $urandom};
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("err_clear_on_start", 64'(bus.err), 64'd0);
    cyc = 1;
    while (!seen_done && cyc < 400) begin
      if (bus.out_valid && lat1 < 0) lat1 = cyc;
      if (bus.done) begin
        seen_done = 1'b1;
        cyc_done  = cyc;
      end
      if (stall) begin
        if (bus.out_valid && hold < 5) begin
          bus.out_ready = 1'b0;
          hold++;
        end else if (bus.out_valid) begin
          bus.out_ready = 1'b1;
          hold = 0;
        end else begin
          bus.out_ready = 1'b0;
        end
        bus.start = bus.busy && !bus.done && cyc[0];
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    if (!seen_done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in 400 cycles, expected done");
      exp_q.delete();
      lat_q.delete();
    end
    check("idle_after_done", 64'(dbg_state), 64'(ST_IDLE));
    check("busy_after_done", 64'(bus.busy), 64'd0);
    check("done_pulses", 64'(done_cnt - done0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat1;
    int cyc_done;

    bus.start     = 1'b0;
    bus.in_data   = '0;
    bus.in_S      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_b", 64'(bus.out_b), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Case 1: fields 101 and 11
    model_packet(64'h1D, 64'h14);
    check("model_c1_f0", 64'(exp_q[0]), 64'h5);
    check("model_c1_f1", 64'(exp_q[1]), 64'h3);
    check("model_c1_len0", 64'(lat_q[0]), 64'd3);
    run_packet(64'h1D, 64'h14, 1'b0, lat1, cyc_done);
    check("c1_first_valid_cycle", 64'(lat1), 64'd4);
    check("c1_err", 64'(bus.err), 64'd0);

    // Case 2: two full-width fields
    model_packet(64'h8000_FFFF, 64'h8000_8000);
    check("model_c2_f0", 64'(exp_q[0]), 64'hFFFF);
    check("model_c2_f1", 64'(exp_q[1]), 64'h8000);
    run_packet(64'h8000_FFFF, 64'h8000_8000, 1'b0, lat1, cyc_done);
    check("c2_first_valid_cycle", 64'(lat1), 64'd17);
    check("c2_err", 64'(bus.err), 64'd0);

    // Case 3: empty packet decodes as zeros
    model_packet(64'h0, 64'h0);
    check("model_c3_f0", 64'(exp_q[0]), 64'h0);
    check("model_c3_len0", 64'(lat_q[0]), 64'd1);
    run_packet(64'h0, 64'h0, 1'b0, lat1, cyc_done);
    check("c3_first_valid_cycle", 64'(lat1), 64'd2);

    // Case 4: 17-bit field -> error after 16 scan cycles, no output
    model_packet(64'h0, 64'h0001_0000);
    check("model_c4_err", 64'(exp_err), 64'd1);
    check("model_c4_no_fields", 64'(exp_q.size()), 64'd0);
    run_packet(64'h0, 64'h0001_0000, 1'b0, lat1, cyc_done);
    check("c4_done_cycle", 64'(cyc_done), 64'd17);
    check("c4_no_valid", 64'(lat1), 64'hFFFF_FFFF_FFFF_FFFF);
    check("c4_err_sticky", 64'(bus.err), 64'd1);

    // Case 1 again clears err (checked at start acceptance)
    model_packet(64'h1D, 64'h14);
    run_packet(64'h1D, 64'h14, 1'b0, lat1, cyc_done);
    check("c4b_err", 64'(bus.err), 64'd0);

    // Case 5: back-pressure plus ignored starts
    model_packet(64'h1D, 64'h14);
    run_packet(64'h1D, 64'h14, 1'b1, lat1, cyc_done);

    // Case 6: reset during the first scan of case 2
    bus.in_data = 64'h8000_FFFF;
    bus.in_S    = 64'h8000_8000;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("c6_scanning", 64'(dbg_state), 64'(ST_SCAN));
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("c6_rst_out_b", 64'(bus.out_b), 64'd0);
    check("c6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("c6_rst_busy", 64'(bus.busy), 64'd0);
    check("c6_rst_done", 64'(bus.done), 64'd0);
    check("c6_rst_err", 64'(bus.err), 64'd0);
    @(posedge clk);
    #1;
    check("c6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_packet(64'h1D, 64'h14);
    run_packet(64'h1D, 64'h14, 1'b0, lat1, cyc_done);
    check("c6_first_valid_cycle", 64'(lat1), 64'd4);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
